// File: rtl/btc_utx2_enc.sv
// btc_utx2_enc: sequential UTX2 block encoder.
// Loads 16 RGB555 pixels, picks luma endpoints, emits 2-bit selectors.
module btc_utx2_enc (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] pixIn,
   input  logic        pixInValid,
   output logic        pixInReady,
   output logic [63:0] blkOut,
   output logic        blkOutValid,
   input  logic        blkOutReady,
   output logic        busy
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      QUANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [3:0]  idx;
   logic [3:0]  qidx;
   logic [14:0] pix [16];
   logic [6:0]  ymin;
   logic [6:0]  ymax;
   logic [14:0] color_a;
   logic [14:0] color_b;
   logic [31:0] sel;

   logic [6:0]  y_in;
   logic [6:0]  y_q;
   logic [11:0] rg;
   logic [11:0] dd;
   logic [11:0] d16;
   logic [11:0] t3;
   logic [11:0] t8;
   logic [11:0] t13;
   logic [1:0]  code;
   logic        first;
   logic        unused_bit15;

   // Bit 15 of the input pixel carries no colour information.
   assign unused_bit15 = pixIn[15];

   function automatic logic [6:0] luma(input logic [14:0] p);
      return {2'b00, p[14:10]} + {1'b0, p[9:5], 1'b0} + {2'b00, p[4:0]};
   endfunction

   assign y_in  = luma(pixIn[14:0]);
   assign y_q   = luma(pix[qidx]);
   assign first = (idx == 4'd0);

   // Threshold compare of the current pixel against the endpoint span.
   always_comb begin
      rg   = {5'b0, ymax - ymin};
      dd   = {5'b0, y_q - ymin};
      d16  = dd << 4;
      t3   = rg * 12'd3;
      t8   = rg << 3;
      t13  = rg * 12'd13;
      code = 2'b00;
      if (d16 < t3) begin
         code = 2'b11;
      end else if (d16 < t8) begin
         code = 2'b01;
      end else if (d16 < t13) begin
         code = 2'b10;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD: begin
            if (pixInValid && idx == 4'd15) begin
               state_nxt = QUANT;
            end
         end
         QUANT: begin
            if (qidx == 4'd15) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (blkOutReady) begin
               state_nxt = LOAD;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Outputs are pure decodes of state and registered data.
   always_comb begin
      pixInReady  = (state == LOAD);
      blkOutValid = (state == DONE);
      busy        = (state != LOAD) || (idx != 4'd0);
      blkOut      = 64'h0;
      if (state == DONE) begin
         blkOut = {sel, 1'b0, color_b, 1'b0, color_a};
      end
   end

   // Pixel buffer, endpoint tracking and selector accumulation.
   always_ff @(posedge clock) begin
      if (!reset) begin
         idx     <= 4'd0;
         qidx    <= 4'd0;
         ymin    <= 7'd0;
         ymax    <= 7'd0;
         color_a <= 15'd0;
         color_b <= 15'd0;
         sel     <= 32'd0;
         for (int i = 0; i < 16; i++) begin
            pix[i] <= 15'd0;
         end
      end else begin
         unique case (state)
            LOAD: begin
               qidx <= 4'd0;
               if (pixInValid) begin
                  pix[idx] <= pixIn[14:0];
                  idx      <= idx + 4'd1;
                  if (first || y_in < ymin) begin
                     ymin    <= y_in;
                     color_a <= pixIn[14:0];
                  end
                  if (first || y_in > ymax) begin
                     ymax    <= y_in;
                     color_b <= pixIn[14:0];
                  end
               end
            end
            QUANT: begin
               sel[{qidx, 1'b0} +: 2] <= code;
               qidx                   <= qidx + 4'd1;
            end
            DONE: begin
               if (blkOutReady) begin
                  idx <= 4'd0;
               end
            end
            default: begin
               idx <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btc_utx2_enc.sv
// tb_btc_utx2_enc: randomized bench for the UTX2 block encoder.
// Expected blocks come from an index-based model of the encoding rules.
module tb_btc_utx2_enc;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pixIn;
   logic        pixInValid;
   logic        pixInReady;
   logic [63:0] blkOut;
   logic        blkOutValid;
   logic        blkOutReady;
   logic        busy;

   btc_utx2_enc dut (
      .clock       (clock),
      .reset       (reset),
      .pixIn       (pixIn),
      .pixInValid  (pixInValid),
      .pixInReady  (pixInReady),
      .blkOut      (blkOut),
      .blkOutValid (blkOutValid),
      .blkOutReady (blkOutReady),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_rise = -1;
   logic [63:0] exp_q [$];
   logic prev_v  = 1'b0;
   logic prev_hs = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] model(input logic [15:0] px [16]);
      int y [16];
      int ia, ib, rg, d, s;
      logic [31:0] sl;
      sl = 32'd0;
      for (int i = 0; i < 16; i++)
         y[i] = px[i][14:10] + 2 * px[i][9:5] + px[i][4:0];
      ia = 0;
      ib = 0;
      for (int i = 1; i < 16; i++) begin
         if (y[i] < y[ia]) ia = i;
         if (y[i] > y[ib]) ib = i;
      end
      rg = y[ib] - y[ia];
      for (int i = 0; i < 16; i++) begin
         d = y[i] - y[ia];
         if (rg == 0)             s = 0;
         else if (16*d < 3*rg)    s = 3;
         else if (16*d < 8*rg)    s = 1;
         else if (16*d < 13*rg)   s = 2;
         else                     s = 0;
         sl[2*i +: 2] = s[1:0];
      end
      return {sl, 1'b0, px[ib][14:0], 1'b0, px[ia][14:0]};
   endfunction

   // Output checker: every valid cycle is compared against the queue head.
   always @(negedge clock) begin
      if (reset) begin
         if (prev_hs) begin
            chk("post_hs_valid", {63'd0, blkOutValid}, 64'd0);
            chk("post_hs_inready", {63'd0, pixInReady}, 64'd1);
         end
         if (blkOutValid) begin
            if (!prev_v && exp_rise >= 0)
               chk("latency", cyc, exp_rise);
            chk("inready_in_done", {63'd0, pixInReady}, 64'd0);
            chk("busy_in_done", {63'd0, busy}, 64'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_blk", {63'd0, blkOutValid}, 64'd0);
            end else begin
               chk("blk", blkOut, exp_q[0]);
               if (blkOutReady) void'(exp_q.pop_front());
            end
         end
         prev_hs = blkOutValid && blkOutReady;
         prev_v  = blkOutValid;
      end else begin
         prev_hs = 1'b0;
         prev_v  = 1'b0;
      end
   end

   task automatic do_reset();
      reset       = 1'b0;
      pixInValid  = 1'b0;
      blkOutReady = 1'b0;
      pixIn       = 16'h0;
      @(posedge clock); #1;
      reset = 1'b1;
      exp_q.delete();
      exp_rise = -1;
      @(negedge clock);
      chk("rst_inready", {63'd0, pixInReady}, 64'd1);
      chk("rst_valid", {63'd0, blkOutValid}, 64'd0);
      chk("rst_blk", blkOut, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      @(posedge clock); #1;
   endtask

   task automatic send_pix(input logic [15:0] px [16], input int n,
                           input int gap);
      int w;
      for (int i = 0; i < n; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) begin
            pixInValid = 1'b0;
            pixIn      = 16'($urandom);
            @(posedge clock); #1;
         end
         pixIn      = px[i];
         pixInValid = 1'b1;
         @(negedge clock);
         w = 0;
         while (!pixInReady && w < 100) begin
            @(negedge clock);
            w++;
         end
         if (!pixInReady) chk("inready_timeout", {63'd0, pixInReady}, 64'd1);
         chk("busy_load", {63'd0, busy}, {63'd0, (i != 0)});
         if (i == 15) exp_rise = cyc + 17;
         @(posedge clock); #1;
      end
      pixInValid = 1'b0;
   endtask

   task automatic send_block(input logic [15:0] px [16], input int gap);
      exp_q.push_back(model(px));
      send_pix(px, 16, gap);
   endtask

   task automatic drain(input int hold, input bit early);
      int n;
      blkOutReady = early;
      n = 0;
      forever begin
         pixInValid = 1'($urandom_range(1));
         pixIn      = 16'($urandom);
         @(negedge clock);
         if (blkOutValid) break;
         n++;
         if (n > 60) begin
            chk("blk_timeout", {63'd0, blkOutValid}, 64'd1);
            break;
         end
         @(posedge clock); #1;
      end
      if (!early) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            pixInValid = 1'($urandom_range(1));
            pixIn      = 16'($urandom);
            @(negedge clock);
         end
         @(posedge clock); #1;
         pixInValid  = 1'b0;
         blkOutReady = 1'b1;
         @(negedge clock);
      end
      @(posedge clock); #1;
      pixInValid  = 1'b0;
      blkOutReady = 1'b0;
      @(negedge clock);
      chk("queue_empty", exp_q.size(), 64'd0);
      @(posedge clock); #1;
   endtask

   logic [15:0] b_uni [16];
   logic [15:0] b_two [16];
   logic [15:0] b_grd [16];
   logic [15:0] b_b15 [16];
   logic [15:0] b_tie [16];
   logic [15:0] b_rnd [16];
   logic [15:0] pal [4];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b0;
      pixInValid  = 1'b0;
      blkOutReady = 1'b0;
      pixIn       = 16'h0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();

      for (int i = 0; i < 16; i++) begin
         b_uni[i] = 16'h7FFF;
         b_two[i] = 16'h7FFF;
         b_grd[i] = 16'h7FFF;
         b_b15[i] = 16'hFFFF;
         b_tie[i] = 16'h7FFF;
      end
      b_two[0] = 16'h0000;
      b_grd[0] = 16'h0000;
      b_grd[1] = 16'h2108;
      b_grd[2] = 16'h4210;
      b_b15[0] = 16'h8000;
      b_tie[0] = 16'h0421;
      b_tie[5] = 16'h0421;

      chk("model_uni", model(b_uni), 64'h00000000_7FFF_7FFF);
      chk("model_two", model(b_two), 64'h00000003_7FFF_0000);
      chk("model_grd", model(b_grd), 64'h00000027_7FFF_0000);
      chk("model_b15", model(b_b15), 64'h00000003_7FFF_0000);
      chk("model_tie", model(b_tie), 64'h00000C03_7FFF_0421);

      send_block(b_uni, 0);
      drain(0, 1'b1);
      send_block(b_two, 0);
      drain(5, 1'b0);
      send_block(b_grd, 0);
      drain(0, 1'b1);
      send_block(b_b15, 0);
      drain(2, 1'b0);
      send_block(b_tie, 0);
      drain(1, 1'b0);
      send_block(b_two, 40);
      drain(3, 1'b0);

      send_pix(b_grd, 7, 0);
      do_reset();
      send_block(b_two, 0);
      drain(0, 1'b1);

      for (int t = 0; t < 30; t++) begin
         for (int j = 0; j < 4; j++) pal[j] = 16'($urandom);
         for (int i = 0; i < 16; i++) begin
            if (t % 2 == 0) b_rnd[i] = pal[$urandom_range(3)];
            else            b_rnd[i] = 16'($urandom);
         end
         send_block(b_rnd, $urandom_range(60));
         drain($urandom_range(4), 1'($urandom_range(1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
